// File: rtl/pulser_spi_pkg.sv
// Shared definitions for the pulser SPI command link.
//  - Frame geometry (6 bytes, MSB first).
//  - Command opcodes carried in byte0[7:4].
//  - State encoding of the spi_cmd_master FSM.
//  - Helper that classifies request opcodes.
//  Request opcodes have bit 3 set; 0xF (trigger) is the exception.
package pulser_spi_pkg;

    localparam int FRAME_BYTES = 6;
    localparam int FRAME_BITS  = FRAME_BYTES * 8;

    localparam logic [3:0] OP_SET_WIDTH  = 4'h1;
    localparam logic [3:0] OP_SET_DELAY  = 4'h2;
    localparam logic [3:0] OP_ENABLE     = 4'h4;
    localparam logic [3:0] OP_SET_MUX    = 4'h5;
    localparam logic [3:0] OP_REQ_WIDTH  = 4'h9;
    localparam logic [3:0] OP_REQ_DELAY  = 4'hA;
    localparam logic [3:0] OP_REQ_ID     = 4'hB;
    localparam logic [3:0] OP_REQ_ENABLE = 4'hC;
    localparam logic [3:0] OP_REQ_MUX    = 4'hD;
    localparam logic [3:0] OP_REQ_BUSY   = 4'hE;
    localparam logic [3:0] OP_TRIGGER    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // A request asks the slave to fill its return buffer.
    // The data only comes back on the following frame.
    function automatic logic is_request(input logic [3:0] op);
        return op[3] && (op != OP_TRIGGER);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider for the SPI master (mode 0).
//  While en is low:
//   - the divider is held at zero;
//   - sck stays low.
//  While en is high:
//   - sck runs CLK_DIV clk low, then CLK_DIV clk high, repeating;
//   - the low phase comes first.
//  Ports:
//   clk, rst     : system clock; synchronous reset, active low
//   en           : run the divider
//   sck          : SCK level (registered)
//   rise_tick    : this clk edge takes SCK high
//   fall_tick    : this clk edge takes SCK low
//   sample_tick  : last clk of the high half; MISO is captured at its closing edge
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick,
    output logic sample_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign rise_tick   = en && !sck && wrap;
    assign fall_tick   = en &&  sck && wrap;
    // Sampling happens at the very edge that drops SCK.
    // The slave's next bit only appears after that edge.
    assign sample_tick = fall_tick;

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 master for the pulser command slave.
//  Operation:
//   - one 48-bit command is sent per SS-low window;
//   - the 48 bits clocked back on MISO are returned as rsp_data.
//  Build option SPI_CMD_MASTER_AUTOREAD_EN:
//   - applies when the accepted command is a request opcode;
//   - an all-zero no-op frame is then sent automatically;
//   - the reply of that second frame is the one reported.
//  Ports:
//   clk, rst             : system clock; synchronous reset, active low
//   cmd_valid/cmd_ready  : command handshake
//   cmd_data             : 48-bit command, byte0 in [47:40]
//   rsp_valid            : one-cycle pulse; rsp_data holds the reply
//   rsp_data             : 48-bit reply
//   busy                 : accept through rsp_valid inclusive
//   spi_sck              : SPI clock, idle low
//   spi_mosi             : SPI data out
//   spi_miso             : SPI data in
//   spi_ss               : slave select, active low
module spi_cmd_master
    import pulser_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SS_SETUP = 2,
    parameter int SS_GAP   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [47:0] cmd_data,
    output logic        rsp_valid,
    output logic [47:0] rsp_data,
    output logic        busy,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_ss
);

    localparam int PH_MAX = (SS_SETUP > SS_GAP) ? SS_SETUP : SS_GAP;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    state_t                state, state_next;
    logic [PH_W-1:0]       phase;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] tx, rx;
    logic                  auto_pend;
    logic                  acc, auto_go, setup_last, gap_last, frame_active;
    logic                  sck_rise_unused, fall_tick, sample_tick;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk         (clk),
        .rst         (rst),
        .en          (state == ST_SHIFT),
        .sck         (spi_sck),
        .rise_tick   (sck_rise_unused),
        .fall_tick   (fall_tick),
        .sample_tick (sample_tick)
    );

    assign acc        = cmd_valid && cmd_ready;
    assign auto_go    = (state == ST_IDLE) && auto_pend;
    assign setup_last = (phase == PH_W'(SS_SETUP - 1));
    assign gap_last   = (phase == PH_W'(SS_GAP - 1));

    // State register.
    // phase restarts on every state change.
    // It therefore counts cycles spent in the current state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            phase <= '0;
        end else begin
            state <= state_next;
            phase <= (state_next != state) ? '0 : phase + PH_W'(1);
        end
    end

    // Next-state logic.
    // The last GAP cycle doubles as an accept cycle.
    // This keeps back-to-back SS-high time at exactly SS_GAP.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (acc || auto_pend)                 state_next = ST_SETUP;
            ST_SETUP: if (setup_last)                       state_next = ST_SHIFT;
            ST_SHIFT: if (fall_tick && bit_cnt == LAST_BIT) state_next = ST_HOLD;
            ST_HOLD:  if (setup_last)                       state_next = ST_GAP;
            ST_GAP:   if (gap_last)                         state_next = acc ? ST_SETUP : ST_IDLE;
            default:                                        state_next = ST_IDLE;
        endcase
    end

    // Datapath registers: pure shift registers, no arithmetic on data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            auto_pend <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (acc) begin
                tx      <= cmd_data;
                bit_cnt <= '0;
`ifdef SPI_CMD_MASTER_AUTOREAD_EN
                auto_pend <= is_request(cmd_data[47:44]);
`else
                auto_pend <= 1'b0;
`endif
            end else if (auto_go) begin
                // Follow-up no-op frame that clocks out the request's reply.
                tx        <= '0;
                bit_cnt   <= '0;
                auto_pend <= 1'b0;
            end else if (fall_tick) begin
                tx      <= {tx[FRAME_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (sample_tick)
                rx <= {rx[FRAME_BITS-2:0], spi_miso};
            // rx is complete once SHIFT ends.
            // Publishing it on GAP entry lets rsp_data be stable when rsp_valid fires.
            if (state == ST_HOLD && setup_last && !auto_pend)
                rsp_data <= rx;
        end
    end

    // Outputs.
    assign frame_active = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);

    always_comb begin
        spi_ss    = !frame_active;
        spi_mosi  = frame_active ? tx[FRAME_BITS-1] : 1'b0;
        cmd_ready = rst && !auto_pend &&
                    ((state == ST_IDLE) || (state == ST_GAP && gap_last));
        rsp_valid = rst && (state == ST_GAP) && gap_last && !auto_pend;
        busy      = (state != ST_IDLE) || auto_pend;
    end

endmodule
